// File: rtl/cpu_addr_seq_if.sv
// Bus/handshake bundle between the CPU core (master) and the effective-address sequencer (slave).
interface cpu_addr_seq_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              ready;
    logic              start;
    logic [3:0]        mode;
    logic              is_store;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic [DATA_W-1:0] d_in;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ea;
    logic [1:0]        op_len;
    logic              page_cross;
    logic              err;

    modport master (
        output ready, start, mode, is_store, pc, x_in, y_in, d_in,
        input  addr, busy, done, ea, op_len, page_cross, err
    );

    modport slave (
        input  ready, start, mode, is_store, pc, x_in, y_in, d_in,
        output addr, busy, done, ea, op_len, page_cross, err
    );
endinterface

// File: rtl/cpu_addr_seq.sv
// Effective-address sequencer: fetches operand/pointer bytes for a decoded 6502 opcode and
// returns the registered effective address, operand length, page-cross and illegal-mode flags.
module cpu_addr_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter bit          ZP_WRAP = 1'b1,
    parameter bit          JMP_BUG = 1'b1
) (
    input logic           clk,
    input logic           reset,
    cpu_addr_seq_if.slave bus
);
    localparam int unsigned HI_W = ADDR_W - DATA_W;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StOp1  = 3'd1;
    localparam logic [2:0] StOp2  = 3'd2;
    localparam logic [2:0] StAdd  = 3'd3;
    localparam logic [2:0] StPtrl = 3'd4;
    localparam logic [2:0] StPtrh = 3'd5;
    localparam logic [2:0] StFix  = 3'd6;
    localparam logic [2:0] StDone = 3'd7;

    localparam logic [3:0] ModeImm  = 4'd0;
    localparam logic [3:0] ModeZp   = 4'd1;
    localparam logic [3:0] ModeZpx  = 4'd2;
    localparam logic [3:0] ModeZpy  = 4'd3;
    localparam logic [3:0] ModeAbs  = 4'd4;
    localparam logic [3:0] ModeAbsx = 4'd5;
    localparam logic [3:0] ModeAbsy = 4'd6;
    localparam logic [3:0] ModeIndx = 4'd7;
    localparam logic [3:0] ModeIndy = 4'd8;
    localparam logic [3:0] ModeInd  = 4'd9;

    logic [2:0]        state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] bal_q, bal_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              cy_q, cy_d;
    logic [ADDR_W-1:0] ea_q;
    logic [1:0]        op_len_q, op_len_d;
    logic              pcross_q;
    logic              err_q, err_d;
    logic              fin;
    logic [ADDR_W-1:0] fin_ea;
    logic [ADDR_W-1:0] addr_c;

    logic [DATA_W:0]   idx_sum;
    logic [ADDR_W-1:0] zp_ea;
    logic [ADDR_W-1:0] ptr_inc;
    logic [HI_W-1:0]   d_hi;
    logic              wrap_ptr;

    // bal_q holds whichever low byte is being indexed: operand BAL, or pointer low byte (INDY)
    assign idx_sum  = {1'b0, bal_q} + {1'b0, idx_q};
    assign zp_ea    = ZP_WRAP ? ADDR_W'(idx_sum[DATA_W-1:0]) : ADDR_W'(idx_sum);
    assign d_hi     = bus.d_in[HI_W-1:0];
    assign wrap_ptr = (mode_q == ModeInd) ? JMP_BUG : ZP_WRAP;
    assign ptr_inc  = wrap_ptr ? {ptr_q[ADDR_W-1:DATA_W], ptr_q[DATA_W-1:0] + DATA_W'(1)}
                               : ptr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        store_d = store_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        bal_d   = bal_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        cy_d    = cy_q;
        fin     = 1'b0;
        fin_ea  = '0;
        addr_c  = '0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    store_d = bus.is_store;
                    pc_d    = bus.pc;
                    cy_d    = 1'b0;
                    idx_d   = (bus.mode == ModeZpy || bus.mode == ModeAbsy ||
                               bus.mode == ModeIndy) ? bus.y_in : bus.x_in;
                    if (bus.mode == ModeImm) begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_ea  = bus.pc;
                    end else if (bus.mode > ModeInd) begin
                        state_d = StDone;
                        fin     = 1'b1;
                    end else begin
                        state_d = StOp1;
                    end
                end
            end
            StOp1: begin
                addr_c = pc_q;
                bal_d  = bus.d_in;
                case (mode_q)
                    ModeZp: begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_ea  = ADDR_W'(bus.d_in);
                    end
                    ModeZpx, ModeZpy, ModeIndx: state_d = StAdd;
                    ModeIndy: begin
                        state_d = StPtrl;
                        ptr_d   = ADDR_W'(bus.d_in);
                    end
                    default: state_d = StOp2;
                endcase
            end
            StOp2: begin
                addr_c = pc_q + ADDR_W'(1);
                base_d = {d_hi, bal_q};
                case (mode_q)
                    ModeAbs: begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_ea  = {d_hi, bal_q};
                    end
                    ModeInd: begin
                        state_d = StPtrl;
                        ptr_d   = {d_hi, bal_q};
                    end
                    default: begin
                        cy_d = idx_sum[DATA_W];
                        if (idx_sum[DATA_W] || store_q) begin
                            state_d = StFix;
                        end else begin
                            state_d = StDone;
                            fin     = 1'b1;
                            fin_ea  = {d_hi, bal_q} + ADDR_W'(idx_q);
                        end
                    end
                endcase
            end
            StAdd: begin
                addr_c = ADDR_W'(bal_q);
                cy_d   = idx_sum[DATA_W];
                if (mode_q == ModeIndx) begin
                    state_d = StPtrl;
                    ptr_d   = zp_ea;
                end else begin
                    state_d = StDone;
                    fin     = 1'b1;
                    fin_ea  = zp_ea;
                end
            end
            StPtrl: begin
                addr_c  = ptr_q;
                bal_d   = bus.d_in;
                state_d = StPtrh;
            end
            StPtrh: begin
                addr_c = ptr_inc;
                base_d = {d_hi, bal_q};
                if (mode_q == ModeIndy) begin
                    cy_d = idx_sum[DATA_W];
                    if (idx_sum[DATA_W] || store_q) begin
                        state_d = StFix;
                    end else begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_ea  = {d_hi, bal_q} + ADDR_W'(idx_q);
                    end
                end else begin
                    state_d = StDone;
                    fin     = 1'b1;
                    fin_ea  = {d_hi, bal_q};
                end
            end
            StFix: begin
                // Dummy read at the high byte before the carry is applied
                addr_c  = {base_q[ADDR_W-1:DATA_W], idx_sum[DATA_W-1:0]};
                state_d = StDone;
                fin     = 1'b1;
                fin_ea  = base_q + ADDR_W'(idx_q);
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d = (mode_d > ModeInd);
        if (err_d) begin
            op_len_d = 2'd0;
        end else if (mode_d == ModeAbs || mode_d == ModeAbsx || mode_d == ModeAbsy ||
                     mode_d == ModeInd) begin
            op_len_d = 2'd2;
        end else begin
            op_len_d = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            store_q  <= 1'b0;
            pc_q     <= '0;
            idx_q    <= '0;
            bal_q    <= '0;
            ptr_q    <= '0;
            base_q   <= '0;
            cy_q     <= 1'b0;
            ea_q     <= '0;
            op_len_q <= '0;
            pcross_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (bus.ready) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            store_q <= store_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            bal_q   <= bal_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            cy_q    <= cy_d;
            if (fin) begin
                ea_q     <= fin_ea;
                op_len_q <= op_len_d;
                pcross_q <= cy_d;
                err_q    <= err_d;
            end
        end
    end

    assign bus.addr       = addr_c;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.ea         = ea_q;
    assign bus.op_len     = op_len_q;
    assign bus.page_cross = pcross_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_cpu_addr_seq.sv
// Bench for cpu_addr_seq: two instances (bug/wrap on, bug/wrap off) checked every cycle
// against an address-list model, plus directed literal expectations.
module tb_cpu_addr_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        start;
    logic        is_store;
    logic [3:0]  mode;
    logic [15:0] pc;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [7:0]  mem [0:65535];

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = ZP_WRAP/JMP_BUG on, 1 = off
    int tr [2][4];
    int tn [2];
    int act [2];
    int pos [2];
    int m_ea [2], m_len [2], m_px [2], m_err [2];
    int e_ea [2], e_len [2], e_px [2], e_err [2];

    always #5 clk = ~clk;

    cpu_addr_seq_if #(.DATA_W(8), .ADDR_W(16)) bus_a ();
    cpu_addr_seq_if #(.DATA_W(8), .ADDR_W(16)) bus_b ();

    assign bus_a.ready = ready;     assign bus_b.ready = ready;
    assign bus_a.start = start;     assign bus_b.start = start;
    assign bus_a.mode = mode;       assign bus_b.mode = mode;
    assign bus_a.is_store = is_store; assign bus_b.is_store = is_store;
    assign bus_a.pc = pc;           assign bus_b.pc = pc;
    assign bus_a.x_in = x_in;       assign bus_b.x_in = x_in;
    assign bus_a.y_in = y_in;       assign bus_b.y_in = y_in;
    assign bus_a.d_in = mem[bus_a.addr];
    assign bus_b.d_in = mem[bus_b.addr];

    cpu_addr_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1'b1), .JMP_BUG(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    cpu_addr_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1'b0), .JMP_BUG(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int rd(input int a);
        return int'(mem[a % 65536]);
    endfunction

    task automatic model_start(input int k);
        int zw, jb, p, b0, b1, idx, s, ptr, p1, lo, hi, n;
        zw  = (k == 0) ? 1 : 0;
        jb  = zw;
        p   = int'(pc);
        b0  = rd(p);
        b1  = rd(p + 1);
        idx = (mode == 4'd3 || mode == 4'd6 || mode == 4'd8) ? int'(y_in) : int'(x_in);
        n = 0;
        m_ea[k] = 0; m_len[k] = 1; m_px[k] = 0; m_err[k] = 0;
        case (int'(mode))
            0: m_ea[k] = p;
            1: begin tr[k][0] = p; n = 1; m_ea[k] = b0; end
            2, 3: begin
                s = b0 + idx;
                tr[k][0] = p; tr[k][1] = b0; n = 2;
                m_px[k] = (s > 255) ? 1 : 0;
                m_ea[k] = zw ? s % 256 : s;
            end
            4: begin
                tr[k][0] = p; tr[k][1] = (p + 1) % 65536; n = 2;
                m_ea[k] = b1 * 256 + b0; m_len[k] = 2;
            end
            5, 6: begin
                s = b0 + idx;
                tr[k][0] = p; tr[k][1] = (p + 1) % 65536; n = 2;
                if (s > 255 || is_store) begin tr[k][2] = b1 * 256 + s % 256; n = 3; end
                m_px[k] = (s > 255) ? 1 : 0;
                m_ea[k] = (b1 * 256 + b0 + idx) % 65536; m_len[k] = 2;
            end
            7: begin
                s   = b0 + idx;
                ptr = zw ? s % 256 : s;
                p1  = zw ? (ptr + 1) % 256 : ptr + 1;
                tr[k][0] = p; tr[k][1] = b0; tr[k][2] = ptr; tr[k][3] = p1; n = 4;
                m_px[k] = (s > 255) ? 1 : 0;
                m_ea[k] = rd(p1) * 256 + rd(ptr);
            end
            8: begin
                p1 = zw ? (b0 + 1) % 256 : b0 + 1;
                lo = rd(b0); hi = rd(p1); s = lo + idx;
                tr[k][0] = p; tr[k][1] = b0; tr[k][2] = p1; n = 3;
                if (s > 255 || is_store) begin tr[k][3] = hi * 256 + s % 256; n = 4; end
                m_px[k] = (s > 255) ? 1 : 0;
                m_ea[k] = (hi * 256 + lo + idx) % 65536;
            end
            9: begin
                ptr = b1 * 256 + b0;
                p1  = jb ? (ptr / 256) * 256 + (ptr + 1) % 256 : (ptr + 1) % 65536;
                tr[k][0] = p; tr[k][1] = (p + 1) % 65536; tr[k][2] = ptr; tr[k][3] = p1; n = 4;
                m_ea[k] = rd(p1) * 256 + rd(ptr); m_len[k] = 2;
            end
            default: begin m_len[k] = 0; m_err[k] = 1; end
        endcase
        tn[k] = n;
    endtask

    task automatic model_step(input int k);
        if (reset) begin
            act[k] = 0; e_ea[k] = 0; e_len[k] = 0; e_px[k] = 0; e_err[k] = 0;
        end else if (ready) begin
            if (act[k] != 0) begin
                pos[k]++;
                if (pos[k] > tn[k]) act[k] = 0;
            end else if (start) begin
                model_start(k);
                act[k] = 1;
                pos[k] = 0;
            end
            if (act[k] != 0 && pos[k] == tn[k]) begin
                e_ea[k] = m_ea[k]; e_len[k] = m_len[k]; e_px[k] = m_px[k]; e_err[k] = m_err[k];
            end
        end
    endtask

    task automatic cmp(input int k, input logic busy, input logic done, input logic [15:0] addr,
                       input logic [15:0] ea, input logic [1:0] op_len, input logic px,
                       input logic err);
        int in_done, want_addr;
        in_done   = (act[k] != 0 && pos[k] == tn[k]) ? 1 : 0;
        want_addr = (act[k] != 0 && pos[k] < tn[k]) ? tr[k][pos[k]] : 0;
        chk($sformatf("busy[%0d]", k), int'(busy), act[k]);
        chk($sformatf("done[%0d]", k), int'(done), in_done);
        chk($sformatf("addr[%0d]", k), int'(addr), want_addr);
        chk($sformatf("ea[%0d]", k), int'(ea), e_ea[k]);
        if (in_done != 0) begin
            chk($sformatf("op_len[%0d]", k), int'(op_len), e_len[k]);
            chk($sformatf("page_cross[%0d]", k), int'(px), e_px[k]);
            chk($sformatf("err[%0d]", k), int'(err), e_err[k]);
        end
    endtask

    initial begin
        act[0] = 0; act[1] = 0; pos[0] = 0; pos[1] = 0; tn[0] = 0; tn[1] = 0;
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        cmp(0, bus_a.busy, bus_a.done, bus_a.addr, bus_a.ea, bus_a.op_len, bus_a.page_cross,
            bus_a.err);
        cmp(1, bus_b.busy, bus_b.done, bus_b.addr, bus_b.ea, bus_b.op_len, bus_b.page_cross,
            bus_b.err);
    end

    task automatic go(input logic [3:0] m, input logic [15:0] p, input logic [7:0] x,
                      input logic [7:0] y, input logic st);
        @(negedge clk);
        mode = m; pc = p; x_in = x; y_in = y; is_store = st; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus_a.busy || bus_b.busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(bus_a.busy || bus_b.busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; ready = 1'b1; start = 1'b0; is_store = 1'b0;
        mode = '0; pc = '0; x_in = '0; y_in = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 7));
        mem[16'h0200] = 8'hF0;
        mem[16'h8000] = 8'h10; mem[16'h8001] = 8'h20;
        mem[16'h0300] = 8'h40; mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'h12;
        mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h30;
        mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h56;
        mem[16'h0500] = 8'h10; mem[16'h0014] = 8'h78; mem[16'h0015] = 8'h56;
        mem[16'h0700] = 8'h33;
        mem[16'h0710] = 8'hF0; mem[16'h0711] = 8'h44;
        mem[16'h0720] = 8'hFF; mem[16'h0721] = 8'hFF;
        mem[16'h0730] = 8'hFE;
        mem[16'h0740] = 8'hFF;
        cyc(3);
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_addr", int'(bus_a.addr), 0);
        chk("rst_done", int'(bus_a.done), 0);
        chk("rst_ea", int'(bus_a.ea), 0);
        chk("rst_op_len", int'(bus_a.op_len), 0);
        chk("rst_page_cross", int'(bus_a.page_cross), 0);
        chk("rst_err", int'(bus_a.err), 0);
        reset = 1'b0;

        // ZPX wrap
        go(4'd2, 16'h0200, 8'h20, 8'h00, 1'b0);
        cyc(1);
        chk("zpx_add_addr", int'(bus_a.addr), 16'h00F0);
        cyc(1);
        chk("zpx_done", int'(bus_a.done), 1);
        chk("zpx_ea_wrap", int'(bus_a.ea), 16'h0010);
        chk("zpx_ea_carry", int'(bus_b.ea), 16'h0110);
        chk("zpx_op_len", int'(bus_a.op_len), 1);
        wait_idle();

        // ABSX load, then store
        go(4'd5, 16'h8000, 8'h05, 8'h00, 1'b0);
        chk("absx_op1_addr", int'(bus_a.addr), 16'h8000);
        cyc(1);
        chk("absx_op2_addr", int'(bus_a.addr), 16'h8001);
        cyc(1);
        chk("absx_done", int'(bus_a.done), 1);
        chk("absx_ea", int'(bus_a.ea), 16'h2015);
        chk("absx_pc", int'(bus_a.page_cross), 0);
        wait_idle();
        go(4'd5, 16'h8000, 8'h05, 8'h00, 1'b1);
        cyc(2);
        chk("absx_st_fix", int'(bus_a.addr), 16'h2015);
        chk("absx_st_nodone", int'(bus_a.done), 0);
        cyc(1);
        chk("absx_st_done", int'(bus_a.done), 1);
        wait_idle();

        // INDY with page cross
        go(4'd8, 16'h0300, 8'h00, 8'h03, 1'b0);
        cyc(3);
        chk("indy_fix_addr", int'(bus_a.addr), 16'h1202);
        cyc(1);
        chk("indy_done", int'(bus_a.done), 1);
        chk("indy_ea", int'(bus_a.ea), 16'h1302);
        chk("indy_pc", int'(bus_a.page_cross), 1);
        wait_idle();

        // JMP (ind) page bug on/off
        go(4'd9, 16'h0400, 8'h00, 8'h00, 1'b0);
        cyc(3);
        chk("jmp_bug_ptrh", int'(bus_a.addr), 16'h3000);
        chk("jmp_nobug_ptrh", int'(bus_b.addr), 16'h3100);
        cyc(1);
        chk("jmp_bug_ea", int'(bus_a.ea), 16'h1234);
        chk("jmp_nobug_ea", int'(bus_b.ea), 16'h5634);
        wait_idle();

        // INDX stalled 3 cycles in PTRL
        go(4'd7, 16'h0500, 8'h04, 8'h00, 1'b0);
        cyc(2);
        chk("indx_ptrl_addr", int'(bus_a.addr), 16'h0014);
        ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("indx_stall_addr", int'(bus_a.addr), 16'h0014);
        end
        ready = 1'b1;
        cyc(1);
        chk("indx_ptrh_addr", int'(bus_a.addr), 16'h0015);
        chk("indx_nodone", int'(bus_a.done), 0);
        cyc(1);
        chk("indx_done_c8", int'(bus_a.done), 1);
        chk("indx_ea", int'(bus_a.ea), 16'h5678);
        wait_idle();

        // Reset in PTRL abandons the op
        go(4'd8, 16'h0300, 8'h00, 8'h03, 1'b0);
        cyc(1);
        chk("rstmid_ptrl_addr", int'(bus_a.addr), 16'h0040);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", int'(bus_a.busy), 0);
        chk("rstmid_addr", int'(bus_a.addr), 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(bus_a.done);
        end
        chk("rstmid_no_done", cnt, 0);

        // Illegal mode, done held by a stall
        go(4'd12, 16'h0900, 8'h00, 8'h00, 1'b0);
        chk("ill_done", int'(bus_a.done), 1);
        chk("ill_err", int'(bus_a.err), 1);
        chk("ill_ea", int'(bus_a.ea), 0);
        chk("ill_op_len", int'(bus_a.op_len), 0);
        ready = 1'b0;
        @(negedge clk);
        chk("ill_done_held", int'(bus_a.done), 1);
        ready = 1'b1;
        @(negedge clk);
        chk("ill_done_end", int'(bus_a.done), 0);
        wait_idle();

        // start while busy (OP1 and DONE cycles) is ignored
        go(4'd4, 16'h8000, 8'h00, 8'h00, 1'b0);
        cnt = int'(bus_a.done);
        mode = 4'd0; start = 1'b1;
        @(negedge clk);
        cnt += int'(bus_a.done);
        start = 1'b0;
        @(negedge clk);
        cnt += int'(bus_a.done);
        chk("busy_done_cycle", int'(bus_a.done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt += int'(bus_a.done);
        repeat (4) begin
            @(negedge clk);
            cnt += int'(bus_a.done);
        end
        chk("single_done", cnt, 1);
        wait_idle();

        // Extra vectors, checked by the model
        go(4'd0, 16'h1234, 8'h00, 8'h00, 1'b0); wait_idle();
        go(4'd1, 16'h0700, 8'h00, 8'h00, 1'b0); wait_idle();
        go(4'd3, 16'h0700, 8'h00, 8'h10, 1'b0); wait_idle();
        go(4'd6, 16'h0710, 8'h00, 8'h20, 1'b0); wait_idle();
        go(4'd5, 16'h0720, 8'h01, 8'h00, 1'b0);
        cyc(2);
        chk("absx_wrap_fix", int'(bus_a.addr), 16'hFF00);
        cyc(1);
        chk("absx_wrap_ea", int'(bus_a.ea), 16'h0000);
        wait_idle();
        go(4'd7, 16'h0730, 8'h01, 8'h00, 1'b0); wait_idle();
        go(4'd8, 16'h0740, 8'h00, 8'h00, 1'b1); wait_idle();
        go(4'd15, 16'h0750, 8'h00, 8'h00, 1'b0); wait_idle();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_addr_seq.md
Name: cpu_addr_seq

Overview:
- Parametrised effective-address sequencer for the 6502-family CPU core.
- Takes over all multi-cycle operand/pointer fetching once the core has decoded an opcode. Drives the bus address and returns a registered effective address (EA).
- Generalises data/address width. Adds correct zero-page wrap, store dummy cycles, JMP (ind) page bug emulation, ready-stall and an error flag, none of which the existing inline FSM has.

Parameters:
- DATA_W, 8: data bus width; one "page" = 2^DATA_W bytes.
- ADDR_W, 16: address bus width; must satisfy DATA_W < ADDR_W <= 2*DATA_W.
- ZP_WRAP, 1: 1 = zero-page index/pointer arithmetic wraps within page 0; 0 = carries into the high byte.
- JMP_BUG, 1: 1 = IND pointer high byte is fetched from {ptr_hi, ptr_lo+1 mod page} (NMOS bug); 0 = ptr+1 with carry.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- ready, in, 1: bus ready; low freezes all state and outputs.
- start, in, 1: one-cycle request; accepted only when busy=0 and ready=1.
- mode, in, 4: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 INDX, 8 INDY, 9 IND; 10-15 illegal.
- is_store, in, 1: sampled at start; forces the FIX cycle for ABSX/ABSY/INDY.
- pc, in, ADDR_W: address of first operand byte; sampled at start.
- x_in, in, DATA_W: X index; sampled at start.
- y_in, in, DATA_W: Y index; sampled at start.
- d_in, in, DATA_W: read data, valid in the same cycle as addr.
- addr, out, ADDR_W: bus address while busy; 0 otherwise.
- busy, out, 1: high from the cycle after start through the DONE cycle.
- done, out, 1: one-cycle pulse; ea, op_len, page_cross and err are valid with it.
- ea, out, ADDR_W: effective address; held until the next done.
- op_len, out, 2: operand bytes consumed (0 for illegal, 1, or 2); the core adds this to PC.
- page_cross, out, 1: index addition carried out of the low byte.
- err, out, 1: illegal mode.

Behaviour:
- reset: state IDLE; addr, busy, done, ea, op_len, page_cross and err all 0. Takes effect mid-sequence; any pending operation is abandoned with no done. reset wins over start.
- ready=0: state, latched bytes and all outputs hold. addr stays stable for the stalled cycle. done, if active, is extended (the core must also be stalled).
- start while busy: ignored.
- States: IDLE, OP1 (addr=pc, latch BAL), OP2 (addr=pc+1, latch BAH), ADD (dummy read {0,BAL}; BAL += idx), PTRL, PTRH, FIX (dummy read at uncorrected {BAH, BAL+idx}), DONE.
- Sequences (states after IDLE; latency = ready-high cycles from start to done):
  - IMM: DONE; ea=pc, op_len=1; latency 1.
  - ZP: OP1, DONE; ea={0,BAL}; latency 2.
  - ZPX/ZPY: OP1, ADD, DONE; ea={0,(BAL+idx) mod 2^DATA_W} if ZP_WRAP else BAL+idx with carry; latency 3.
  - ABS: OP1, OP2, DONE; ea={BAH,BAL}; latency 3.
  - ABSX/ABSY: OP1, OP2, [FIX], DONE; ea={BAH,BAL}+idx. FIX is inserted iff carry or is_store; latency 3 or 4.
  - INDX: OP1, ADD, PTRL (addr={0,p}), PTRH (addr={0,p+1}, wraps per ZP_WRAP), DONE, where p=BAL+X; ea={hi,lo}; latency 5.
  - INDY: OP1, PTRL (addr={0,BAL}), PTRH ({0,BAL+1}, wraps), [FIX], DONE; ea={hi,lo}+Y; FIX iff carry or is_store; latency 4 or 5.
  - IND: OP1, OP2, PTRL (addr={BAH,BAL}), PTRH (per JMP_BUG), DONE; latency 5.
  - Illegal mode: DONE with err=1, ea=0, op_len=0; latency 1.
- op_len: 2 for ABS/ABSX/ABSY/IND; 1 otherwise.
- High-byte fields are truncated to ADDR_W-DATA_W bits. All sums are modulo 2^ADDR_W; ea=0xFFFF + 1 wraps to 0x0000.
- Back-to-back: start may be asserted in the DONE cycle? No: busy=1 there, so start is ignored. The earliest next start is the cycle after DONE.

Test Plan:
- ZPX wrap: mode=2, BAL=0xF0, X=0x20, ZP_WRAP=1 -> ADD addr=0x00F0; done at cycle 3 with ea=0x0010, op_len=1.
- ABSX load, no cross: pc=0x8000, bytes 0x10,0x20, X=0x05 -> OP1 addr 0x8000, OP2 addr 0x8001, done at cycle 3, ea=0x2015, page_cross=0. Same with is_store=1 -> FIX addr 0x2015, done at cycle 4.
- INDY cross: BAL=0x40, mem[0x40]=0xFF, mem[0x41]=0x12, Y=0x03 -> FIX addr 0x1202; done at cycle 5 with ea=0x1302, page_cross=1.
- JMP bug: mode=9, operand 0x30FF, JMP_BUG=1 -> PTRH addr=0x3000; JMP_BUG=0 -> PTRH addr=0x3100.
- Stall/reset: ready low for 3 cycles inside INDX -> addr held and latency extended by 3. reset in PTRL -> next cycle busy=0, addr=0, no done.
- Illegal mode=12 -> done at cycle 1, err=1, ea=0, op_len=0. start while busy -> ignored, no second done.
